multi_lane_lot_counter: RTL and testbench

- Parametrised successor to the single-gate parking-lot counter: N_LANES independent gates, each with an A/B beam-sensor pair, one shared occupancy register.
- Per-lane direction FSM decodes A-then-B (entry) vs B-then-A (exit) sequences. Backtracking and illegal jumps are tolerated.
- All lanes' events are summed into a saturating occupancy count, with full/empty flags and sticky over/underflow errors.
- Sits between the raw gate sensors and the lot display/controller.

---
 rtl/multi_lane_lot_counter.sv | 166 ++++++++++++++++
 tb/tb_multi_lane_lot_counter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multi_lane_lot_counter.sv
// Multi-gate parking-lot occupancy counter: per-lane A/B beam direction FSMs feeding a saturating shared count.
// Optional per-bit input debounce filter is enabled by defining MULTI_LANE_LOT_DEBOUNCE_EN.
`timescale 1ns/1ps
module multi_lane_lot_counter #(
  parameter int N_LANES    = 2,
  parameter int CAP        = 15,
  parameter int CNT_W      = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_LANES-1:0] a,
  input  logic [N_LANES-1:0] b,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   no_cars,
  output logic               full,
  output logic               empty,
  output logic [N_LANES-1:0] car_in,
  output logic [N_LANES-1:0] car_out,
  output logic [N_LANES-1:0] seq_err,
  output logic               ovf_err,
  output logic               unf_err
);

  localparam logic [2:0] IDLE = 3'd0, EN1 = 3'd1, EN2 = 3'd2, EN3 = 3'd3;
  localparam logic [2:0] EX1  = 3'd4, EX2 = 3'd5, EX3 = 3'd6, ERR = 3'd7;
  localparam logic signed [CNT_W+3:0] CAP_S = (CNT_W+4)'(CAP);

  if ((2**CNT_W) <= CAP || N_LANES < 1 || N_LANES > 8 || DEB_CYCLES < 1) begin : param_check_g
    $error("multi_lane_lot_counter: illegal parameter combination");
  end

  // a bits occupy the upper half, b bits the lower half
  logic [2*N_LANES-1:0] sync1_q, sync2_q, filt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {a, b};
      sync2_q <= sync1_q;
    end
  end

`ifdef MULTI_LANE_LOT_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  for (genvar gi = 0; gi < 2*N_LANES; gi++) begin : deb_g
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;

    // Counter only runs while the synchronised bit disagrees with the filtered bit.
    always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync2_q[gi] != filt_q) begin
        if (cnt_q == DEB_W'(DEB_CYCLES - 1)) filt_d = sync2_q[gi];
        else                                 cnt_d  = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end

    assign filt[gi] = filt_q;
  end
`else
  assign filt = sync2_q;
`endif

  for (genvar gi = 0; gi < N_LANES; gi++) begin : lane_g
    logic [1:0] ab;
    logic [2:0] state_q, state_d;
    logic       in_q, in_d, out_q, out_d, err_q, err_d;

    assign ab = {filt[N_LANES+gi], filt[gi]};

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= IDLE;
        in_q    <= 1'b0;
        out_q   <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        in_q    <= in_d;
        out_q   <= out_d;
        err_q   <= err_d;
      end
    end

    // Any pattern not listed for a state simply holds it.
    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE: case (ab) 2'b10: state_d = EN1;  2'b01: state_d = EX1;  2'b11: state_d = ERR; default: ; endcase
        EN1:  case (ab) 2'b11: state_d = EN2;  2'b00: state_d = IDLE; 2'b01: state_d = ERR; default: ; endcase
        EN2:  case (ab) 2'b01: state_d = EN3;  2'b10: state_d = EN1;  2'b00: state_d = ERR; default: ; endcase
        EN3:  case (ab) 2'b00: state_d = IDLE; 2'b11: state_d = EN2;  2'b10: state_d = ERR; default: ; endcase
        EX1:  case (ab) 2'b11: state_d = EX2;  2'b00: state_d = IDLE; 2'b10: state_d = ERR; default: ; endcase
        EX2:  case (ab) 2'b10: state_d = EX3;  2'b01: state_d = EX1;  2'b00: state_d = ERR; default: ; endcase
        EX3:  case (ab) 2'b00: state_d = IDLE; 2'b11: state_d = EX2;  2'b01: state_d = ERR; default: ; endcase
        default: if (ab == 2'b00) state_d = IDLE;
      endcase
    end

    always_comb begin
      in_d  = (state_q == EN3) && (ab == 2'b00);
      out_d = (state_q == EX3) && (ab == 2'b00);
      err_d = (state_d == ERR) && (state_q != ERR);
    end

    assign car_in[gi]  = in_q;
    assign car_out[gi] = out_q;
    assign seq_err[gi] = err_q;
  end

  logic [CNT_W-1:0]        no_cars_q, no_cars_d;
  logic                    ovf_q, ovf_d, unf_q, unf_d;
  logic [3:0]              n_in, n_out;
  logic signed [CNT_W+3:0] next_sum;
  logic                    ovf_evt, unf_evt;

  // Entries and exits on different lanes net out before the clamp is applied.
  always_comb begin
    n_in  = '0;
    n_out = '0;
    for (int i = 0; i < N_LANES; i++) begin
      n_in  = n_in  + 4'(car_in[i]);
      n_out = n_out + 4'(car_out[i]);
    end
    next_sum  = $signed({4'b0000, no_cars_q}) + $signed({{CNT_W{1'b0}}, n_in})
              - $signed({{CNT_W{1'b0}}, n_out});
    ovf_evt   = next_sum > CAP_S;
    unf_evt   = next_sum[CNT_W+3];
    no_cars_d = ovf_evt ? CNT_W'(CAP) : (unf_evt ? '0 : next_sum[CNT_W-1:0]);
    ovf_d     = ovf_evt | (ovf_q & ~err_clr);
    unf_d     = unf_evt | (unf_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      no_cars_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      no_cars_q <= no_cars_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign no_cars = no_cars_q;
  assign full    = (no_cars_q == CNT_W'(CAP));
  assign empty   = (no_cars_q == '0);
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule

// File: tb/tb_multi_lane_lot_counter.sv
// Scoreboard bench for multi_lane_lot_counter: stimulus queues expected lane pulses, a monitor pops them on every pulse.
`timescale 1ns/1ps
module tb_multi_lane_lot_counter;
  localparam int NL = 2;
  localparam int CW = 4;
  localparam logic [11:0] ENTRY = {4'b0000, 2'b00, 2'b01, 2'b11, 2'b10};
  localparam logic [11:0] EXIT  = {4'b0000, 2'b00, 2'b10, 2'b11, 2'b01};

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NL-1:0] a = '0, b = '0;
  logic          err_clr = 1'b0;
  logic [CW-1:0] no_cars;
  logic          full, empty, ovf_err, unf_err;
  logic [NL-1:0] car_in, car_out, seq_err;

  multi_lane_lot_counter #(.N_LANES(NL), .CAP(15), .CNT_W(CW), .DEB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .err_clr(err_clr),
    .no_cars(no_cars), .full(full), .empty(empty),
    .car_in(car_in), .car_out(car_out), .seq_err(seq_err),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ci;
    logic [1:0] co;
    logic [1:0] se;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_ev(input logic [1:0] ci, input logic [1:0] co, input logic [1:0] se);
    ev_t e;
    e.ci = ci; e.co = co; e.se = se;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse the DUT emits must match the oldest queued expectation.
  always @(negedge clk) begin
    ev_t e;
    if (reset && ((car_in | car_out | seq_err) != '0)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: car_in=%b car_out=%b seq_err=%b, expected no event (t=%0t)",
                 car_in, car_out, seq_err, $time);
      end else begin
        e = exp_q.pop_front();
        chk("ev_car_in",  32'(car_in),  32'(e.ci));
        chk("ev_car_out", 32'(car_out), 32'(e.co));
        chk("ev_seq_err", 32'(seq_err), 32'(e.se));
        $display("event: car_in=%b car_out=%b seq_err=%b no_cars=%0d", car_in, car_out, seq_err, no_cars);
      end
    end
  end

  task automatic set_lane(input int l, input logic [1:0] ab);
    a[l] = ab[1];
    b[l] = ab[0];
  endtask

  // Apply n patterns to one lane, first pattern in the low bits, each held 3 clocks.
  task automatic run_seq(input int l, input int n, input logic [11:0] p);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_lane(l, p[2*i +: 2]);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic run_pair(input logic [11:0] p0, input logic [11:0] p1, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_lane(0, p0[2*i +: 2]);
      set_lane(1, p1[2*i +: 2]);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_count(input string name, input int n);
    chk(name, 32'(no_cars), 32'(n));
    $display("%s: no_cars=%0d full=%b empty=%b ovf=%b unf=%b", name, no_cars, full, empty, ovf_err, unf_err);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_count("reset_no_cars", 0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_ovf", 32'(ovf_err), 32'd0);
    chk("reset_unf", 32'(unf_err), 32'd0);
    chk("reset_pulses", 32'({car_in, car_out, seq_err}), 32'd0);
    reset = 1'b1;

    expect_ev(2'b01, 2'b00, 2'b00);
    run_seq(0, 4, ENTRY); settle();
    chk_count("entry1", 1);
    chk("entry1_empty", 32'(empty), 32'd0);

    expect_ev(2'b01, 2'b00, 2'b00);
    run_seq(0, 4, ENTRY); settle();
    chk_count("entry2", 2);

    expect_ev(2'b00, 2'b10, 2'b00);
    run_seq(1, 4, EXIT); settle();
    chk_count("exit_lane1", 1);

    run_seq(1, 2, {8'b0, 2'b00, 2'b10}); settle();
    chk_count("abort_lane1", 1);

    expect_ev(2'b00, 2'b00, 2'b01);
    run_seq(0, 3, {6'b0, 2'b00, 2'b11, 2'b00}); settle();
    chk_count("illegal_jump", 1);

    expect_ev(2'b01, 2'b00, 2'b00);
    run_seq(0, 6, {2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b10}); settle();
    chk_count("backtrack", 2);

    for (int i = 0; i < 13; i++) begin
      expect_ev(2'b01, 2'b00, 2'b00);
      run_seq(0, 4, ENTRY);
    end
    settle();
    chk_count("fill", 15);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ovf", 32'(ovf_err), 32'd0);

    expect_ev(2'b01, 2'b10, 2'b00);
    run_pair(ENTRY, EXIT, 4); settle();
    chk_count("simul_at_cap", 15);
    chk("simul_ovf", 32'(ovf_err), 32'd0);

    expect_ev(2'b01, 2'b00, 2'b00);
    run_seq(0, 4, ENTRY); settle();
    chk_count("overflow", 15);
    chk("overflow_full", 32'(full), 32'd1);
    chk("overflow_ovf", 32'(ovf_err), 32'd1);

    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("err_clr_ovf", 32'(ovf_err), 32'd0);

    for (int i = 0; i < 15; i++) begin
      expect_ev(2'b00, 2'b10, 2'b00);
      run_seq(1, 4, EXIT);
    end
    settle();
    chk_count("drain", 0);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_unf", 32'(unf_err), 32'd0);

    expect_ev(2'b00, 2'b10, 2'b00);
    run_seq(1, 4, EXIT); settle();
    chk_count("underflow", 0);
    chk("underflow_unf", 32'(unf_err), 32'd1);

    run_seq(0, 2, {8'b0, 2'b11, 2'b10}); settle();
    expect_ev(2'b00, 2'b00, 2'b01);
    @(negedge clk);
    #2 reset = 1'b0;
    #0.5;
    chk_count("midreset_no_cars", 0);
    chk("midreset_empty", 32'(empty), 32'd1);
    chk("midreset_unf", 32'(unf_err), 32'd0);
    chk("midreset_ovf", 32'(ovf_err), 32'd0);
    #0.5 reset = 1'b1;
    repeat (5) @(negedge clk);
    run_seq(0, 1, {10'b0, 2'b00}); settle();
    chk_count("after_reset", 0);
    chk("after_reset_unf", 32'(unf_err), 32'd0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
